snd_req_arb: RTL and testbench

Arbiter and sequencer sharing the single sound manager (piezo driver) among several requesters: countdown, hit/miss, stage/game result. It sits between the game FSMs and the sound manager's `snd_mode`/`trig`/`playing` handshake. It holds one pending request per requester and issues one sound at a time. It enforces a silence gap between sounds and recovers from a sound manager that never starts.

---
 rtl/snd_req_arb.sv | 164 ++++++++++++++++
 tb/tb_snd_req_arb.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snd_req_arb.sv
// Arbiter/sequencer sharing one piezo sound manager among N_REQ requesters.
// Define SND_REQ_ARB_RR_EN for round-robin arbitration; otherwise the lowest pending index wins.
module snd_req_arb #(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 50000,
  parameter int START_TO   = 16
) (
  input  logic               clk_1mhz,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] req_mode,
  input  logic               flush,
  input  logic               snd_playing,
  output logic [2:0]         snd_mode,
  output logic               snd_trig,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   drop,
  output logic               busy,
  output logic               err_timeout
);

  localparam int CNT_MAX = (GAP_CYCLES > START_TO) ? GAP_CYCLES : START_TO;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CW-1:0] START_LOAD = CW'((START_TO > 0) ? START_TO - 1 : 0);
  localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_PLAYING,
    S_GAP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [N_REQ-1:0] pend;
  logic [2:0]      pend_mode [N_REQ];
  logic [IW-1:0]   winner;
  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic            issue;
  logic            timeout;

  assign busy = (state != S_IDLE);

`ifdef SND_REQ_ARB_RR_EN
  logic [IW-1:0] last_grant;

  // Scan downwards in offset so the nearest index after the last grant wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (pend[(int'(last_grant) + k) % N_REQ]) begin
        pick     = IW'((int'(last_grant) + k) % N_REQ);
        pick_vld = 1'b1;
      end
    end
  end
`else
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (pend[k]) begin
        pick     = IW'(k);
        pick_vld = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    issue     = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_vld) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        issue     = 1'b1;
        state_nxt = S_WAIT_START;
        cnt_nxt   = START_LOAD;
      end
      S_WAIT_START: begin
        if (snd_playing) begin
          state_nxt = S_PLAYING;
        end else if (cnt == '0) begin
          timeout   = 1'b1;
          state_nxt = S_GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_PLAYING: begin
        if (!snd_playing) begin
          if (GAP_CYCLES == 0) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_GAP;
            cnt_nxt   = GAP_LOAD;
          end
        end
      end
      S_GAP: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The served entry is cleared on issue, but a same-cycle request for it re-arms it without a drop.
  always_ff @(posedge clk_1mhz) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      winner      <= '0;
      snd_mode    <= '0;
      snd_trig    <= 1'b0;
      grant       <= '0;
      drop        <= '0;
      err_timeout <= 1'b0;
      pend        <= '0;
      for (int i = 0; i < N_REQ; i++) pend_mode[i] <= '0;
`ifdef SND_REQ_ARB_RR_EN
      last_grant  <= IW'(N_REQ - 1);
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      snd_trig    <= issue;
      grant       <= issue ? (N_REQ'(1) << winner) : '0;
      err_timeout <= err_timeout | timeout;
      if (issue) snd_mode <= pend_mode[winner];
      if (state == S_IDLE && pick_vld) begin
        winner <= pick;
`ifdef SND_REQ_ARB_RR_EN
        last_grant <= pick;
`endif
      end
      for (int i = 0; i < N_REQ; i++) begin
        drop[i] <= 1'b0;
        if (flush) begin
          pend[i] <= 1'b0;
        end else if (req[i]) begin
          pend[i]      <= 1'b1;
          pend_mode[i] <= req_mode[3*i +: 3];
          drop[i]      <= pend[i] & ~(issue && (winner == IW'(i)));
        end else if (issue && (winner == IW'(i))) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_snd_req_arb.sv
// Self-checking bench for snd_req_arb: vector table, directed corner sequences and a
// randomized run against a timeline-based reference model.
module tb_snd_req_arb;

  localparam int N = 4;
  localparam int G = 5;
  localparam int S = 6;
  localparam longint BIG = longint'(1) << 40;

  logic           clk_1mhz = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [3*N-1:0] req_mode = '0;
  logic           flush = 1'b0;
  logic           snd_playing = 1'b0;
  logic [2:0]     snd_mode;
  logic           snd_trig;
  logic [N-1:0]   grant;
  logic [N-1:0]   drop;
  logic           busy;
  logic           err_timeout;

  snd_req_arb #(.N_REQ(N), .GAP_CYCLES(G), .START_TO(S)) dut (
    .clk_1mhz(clk_1mhz), .rst_n(rst_n), .req(req), .req_mode(req_mode), .flush(flush),
    .snd_playing(snd_playing), .snd_mode(snd_mode), .snd_trig(snd_trig), .grant(grant),
    .drop(drop), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk_1mhz = ~clk_1mhz;

  int n_cmp = 0;
  int n_bad = 0;
  longint ecount = 0;

  // sound manager environment: start delay / length of the next sound
  int     next_d = 1;
  int     next_len = 4;
  bit     next_never = 1'b0;
  bit     rand_env = 1'b0;
  longint play_start = -1;
  longint play_end = -1;

  // reference model: pending store plus a timeline of when the arbiter is next idle
  logic [N-1:0] m_pend;
  logic [2:0]   m_mode [N];
  logic [2:0]   m_snd_mode;
  logic         m_trig, m_err, m_busy;
  logic [N-1:0] m_grant, m_drop;
  longint       m_idle_from, m_trig_edge, m_err_edge;
  int           m_win, m_last;

  int           got_idx [$];
  logic [2:0]   got_mode [$];

  typedef struct packed {
    logic [3:0]  rq;
    logic [11:0] modes;
    logic [2:0]  n;
    logic [7:0]  order;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ecount);
    end
  endtask

  function automatic int pick_winner(input logic [N-1:0] p, input int last);
`ifdef SND_REQ_ARB_RR_EN
    for (int k = 1; k <= N; k++) if (p[(last + k) % N]) return (last + k) % N;
`else
    for (int k = 0; k < N; k++) if (p[k]) return k;
`endif
    return 0;
  endfunction

  task automatic randomize_env();
    next_never = ($urandom_range(0, 7) == 0);
    next_d     = $urandom_range(0, 3);
    next_len   = $urandom_range(1, 12);
  endtask

  task automatic model_step();
    logic [N-1:0] clr;
    logic [N-1:0] base;
    if (!rst_n) begin
      m_pend = '0;
      for (int i = 0; i < N; i++) m_mode[i] = '0;
      m_snd_mode = '0; m_trig = 0; m_grant = '0; m_drop = '0; m_err = 0;
      m_idle_from = ecount; m_trig_edge = -1; m_err_edge = -1; m_last = N - 1; m_win = 0;
      m_busy = 0;
      return;
    end
    m_trig = 0; m_grant = '0; m_drop = '0; clr = '0;
    if (ecount == m_trig_edge) begin
      m_trig = 1;
      m_grant[m_win] = 1'b1;
      m_snd_mode = m_mode[m_win];
      clr[m_win] = 1'b1;
      if (next_never) begin
        m_idle_from = ecount + S + G;
        m_err_edge  = ecount + S;
      end else begin
        m_idle_from = ecount + next_d + next_len + 1 + G;
      end
    end else if (ecount - 1 >= m_idle_from && m_pend != '0) begin
      m_win = pick_winner(m_pend, m_last);
      m_last = m_win;
      m_trig_edge = ecount + 1;
      m_idle_from = BIG;
    end
    if (ecount == m_err_edge) m_err = 1;
    base = m_pend & ~clr;
    if (flush) begin
      m_pend = '0;
    end else begin
      m_drop = base & req;
      m_pend = base | req;
      for (int i = 0; i < N; i++) if (req[i]) m_mode[i] = req_mode[3*i +: 3];
    end
    m_busy = (ecount < m_idle_from);
  endtask

  task automatic env_update();
    if (!rst_n) begin
      play_start = -1; play_end = -1;
    end else if (snd_trig === 1'b1) begin
      if (next_never) begin
        play_start = -1; play_end = -1;
      end else begin
        play_start = ecount + next_d;
        play_end   = play_start + next_len;
      end
      if (rand_env) randomize_env();
    end
    snd_playing = (ecount >= play_start && ecount < play_end);
  endtask

  task automatic checkOutput();
    check("cyc_trig", 32'(snd_trig), 32'(m_trig));
    check("cyc_grant", 32'(grant), 32'(m_grant));
    check("cyc_drop", 32'(drop), 32'(m_drop));
    check("cyc_busy", 32'(busy), 32'(m_busy));
    check("cyc_err", 32'(err_timeout), 32'(m_err));
    check("cyc_mode", 32'(snd_mode), 32'(m_snd_mode));
  endtask

  task automatic step();
    @(posedge clk_1mhz);
    ecount++;
    model_step();
    #1;
    env_update();
    checkOutput();
  endtask

  task automatic do_reset();
    rst_n = 0; req = '0; flush = 0;
    step(); step();
    rst_n = 1;
  endtask

  task automatic wait_trig(input int budget, input string name);
    int n = 0;
    while (snd_trig !== 1'b1 && n < budget) begin step(); n++; end
    n_cmp++;
    if (snd_trig !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL %s: no snd_trig within %0d cycles, required one", name, budget);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin step(); n++; end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic collect(input int cycles);
    got_idx.delete(); got_mode.delete();
    for (int j = 0; j < cycles; j++) begin
      step();
      if (snd_trig === 1'b1) begin
        got_idx.push_back($onehot(grant) ? $clog2(grant) : -1);
        got_mode.push_back(snd_mode);
      end
    end
  endtask

  task automatic applyStimulus(input int t);
    int n;
    int e;
    logic [11:0] mw;
    logic [7:0]  ord;
    do_reset();
    next_never = 0; next_d = 1; next_len = 3;
    req = tbl[t].rq; req_mode = tbl[t].modes;
    step();
    req = '0;
    collect(120);
    n = int'(tbl[t].n); mw = tbl[t].modes; ord = tbl[t].order;
    check($sformatf("tbl%0d_count", t), 32'(got_idx.size()), 32'(n));
    for (int j = 0; j < n; j++) begin
      if (j < got_idx.size()) begin
        e = int'(ord[2*j +: 2]);
        check($sformatf("tbl%0d_grant%0d", t, j), 32'(got_idx[j]), 32'(e));
        check($sformatf("tbl%0d_mode%0d", t, j), 32'(got_mode[j]), 32'(mw[3*e +: 3]));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int busy_cnt;
    int trig_cnt;
    int want [$];

    tbl[0] = '{4'b0100, 12'h0C0, 3'd1, 8'h02};
    tbl[1] = '{4'b1011, 12'h5A3, 3'd3, 8'h34};
    tbl[2] = '{4'b1111, 12'hFAC, 3'd4, 8'hE4};
    tbl[3] = '{4'b1000, 12'hE00, 3'd1, 8'h03};
    tbl[4] = '{4'b0110, 12'h1D8, 3'd2, 8'h09};
    tbl[5] = '{4'b1001, 12'h807, 3'd2, 8'h0C};

    // reset with all requests held, then request-to-trigger latency
    rst_n = 0; req = 4'b1111; req_mode = 12'hFFF;
    step(); step();
    check("rst_trig", 32'(snd_trig), 0); check("rst_grant", 32'(grant), 0);
    check("rst_drop", 32'(drop), 0);     check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err_timeout), 0); check("rst_mode", 32'(snd_mode), 0);
    rst_n = 1; req = '0;
    step(); step(); step();
    check("rst_pend_empty", 32'(busy), 0);
    req = 4'b0001; req_mode = 12'h005;
    step();
    req = '0;
    check("lat_k_trig", 32'(snd_trig), 0);
    step();
    check("lat_k1_trig", 32'(snd_trig), 0); check("lat_k1_busy", 32'(busy), 1);
    step();
    check("lat_k2_trig", 32'(snd_trig), 1); check("lat_k2_mode", 32'(snd_mode), 5);
    check("lat_k2_grant", 32'(grant), 32'h1);
    wait_idle(100, "lat_idle");

    // single 100-cycle sound: busy duration
    next_d = 1; next_len = 100;
    req = 4'b0100; req_mode = 12'h0C0;
    step();
    req = '0;
    busy_cnt = 0; trig_cnt = 0;
    for (int j = 0; j < 500; j++) begin
      step();
      if (snd_trig === 1'b1) begin
        trig_cnt++;
        check("single_mode", 32'(snd_mode), 3);
        check("single_grant", 32'(grant), 32'h4);
      end
      if (busy === 1'b1) busy_cnt++;
      else if (busy_cnt > 0) break;
    end
    check("single_trigs", 32'(trig_cnt), 1);
    check("single_busy_len", 32'(busy_cnt), 32'(1 + 2 + 100 + G));

    for (int t = 0; t < 6; t++) applyStimulus(t);

    // contention after an initial grant of 1
    do_reset();
    next_d = 1; next_len = 3;
    req = 4'b0010; req_mode = 12'h000;
    step(); req = '0;
    wait_trig(10, "rr_first");
    check("rr_first_grant", 32'(grant), 32'h2);
    wait_idle(50, "rr_first_idle");
    req = 4'b1011; step(); req = '0;
    collect(120);
`ifdef SND_REQ_ARB_RR_EN
    want = '{3, 0, 1};
`else
    want = '{0, 1, 3};
`endif
    check("rr_count", 32'(got_idx.size()), 3);
    for (int j = 0; j < 3; j++)
      if (j < got_idx.size()) check($sformatf("rr_order%0d", j), 32'(got_idx[j]), 32'(want[j]));

    // overwrite of a pending request while another sound plays
    do_reset();
    next_d = 1; next_len = 10;
    req = 4'b0001; req_mode = 12'h000;
    step(); req = '0;
    wait_trig(10, "ovw_first");
    step(); step();
    req = 4'b0010; req_mode = 12'h008;
    step(); req = '0;
    check("ovw_first_req_drop", 32'(drop), 0);
    req = 4'b0010; req_mode = 12'h020;
    step(); req = '0;
    check("ovw_drop", 32'(drop), 32'h2);
    step();
    check("ovw_drop_width", 32'(drop), 0);
    wait_trig(100, "ovw_second");
    check("ovw_grant", 32'(grant), 32'h2);
    check("ovw_mode", 32'(snd_mode), 4);
    wait_idle(100, "ovw_idle");
    trig_cnt = 0;
    for (int j = 0; j < 20; j++) begin step(); if (snd_trig === 1'b1) trig_cnt++; end
    check("ovw_no_extra", 32'(trig_cnt), 0);

    // flush during PLAYING
    do_reset();
    next_d = 1; next_len = 10;
    req = 4'b0001; step(); req = '0;
    wait_trig(10, "flush_first");
    step(); step(); step();
    req = 4'b1110; step(); req = '0;
    step();
    flush = 1; step(); flush = 0;
    check("flush_keeps_sound", 32'(busy), 1);
    trig_cnt = 0;
    for (int j = 0; j < 60; j++) begin step(); if (snd_trig === 1'b1) trig_cnt++; end
    check("flush_no_issue", 32'(trig_cnt), 0);
    check("flush_idle", 32'(busy), 0);

    // start timeout, then the queued request is still served
    do_reset();
    next_never = 1;
    req = 4'b1000; step(); req = '0;
    wait_trig(10, "to_first");
    next_never = 0; next_d = 0; next_len = 3;
    req = 4'b0010; step(); req = '0;
    for (int j = 0; j < S - 2; j++) step();
    check("to_before", 32'(err_timeout), 0);
    step();
    check("to_set", 32'(err_timeout), 1);
    check("to_gap_busy", 32'(busy), 1);
    wait_trig(60, "to_next");
    check("to_next_grant", 32'(grant), 32'h2);
    check("to_sticky", 32'(err_timeout), 1);
    wait_idle(60, "to_idle");

    // reset in the middle of a sound
    next_d = 1; next_len = 20;
    req = 4'b0001; step(); req = '0;
    wait_trig(10, "mid_first");
    step(); step(); step();
    rst_n = 0; step();
    check("mid_busy", 32'(busy), 0); check("mid_err", 32'(err_timeout), 0);
    rst_n = 1; step(); step();
    check("mid_stays_idle", 32'(busy), 0);

    // randomized traffic against the reference model
    rand_env = 1; randomize_env();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 999) != 0);
      for (int i = 0; i < N; i++) req[i] = ($urandom_range(0, 11) == 0);
      req_mode = 12'($urandom);
      flush = ($urandom_range(0, 47) == 0);
      step();
    end
    rst_n = 1; req = '0; flush = 0;
    wait_idle(400, "rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
